// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stall/flush sequencer.
//   state_e : sequencer states (INIT, RUN, LD_STALL, MEM_WAIT)
//   ctrl_t  : packed enable/flush bundle driven to the stage registers
//   CTRL_*  : canned bundles for each pipeline situation
package pipe_pkg;

    localparam int unsigned WAIT_W = 8;   // memory-wait counter width
    localparam int unsigned BUB_W  = 2;   // load-use bubble counter width
    localparam int unsigned PERF_W = 32;  // performance counter width

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_LD_STALL,
        ST_MEM_WAIT
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Free-running pipeline.
    localparam ctrl_t CTRL_BASE = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                    mem_wb_flush: 1'b0};
    // Out of reset: hold PC, clear every stage that can carry a NOP.
    localparam ctrl_t CTRL_INIT = '{pc_en: 1'b0, if_id_en: 1'b1, id_ex_en: 1'b1,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                    if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                    mem_wb_flush: 1'b1};
    // Taken branch: squash the two younger instructions, PC loads target.
    localparam ctrl_t CTRL_BR   = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                    if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                    mem_wb_flush: 1'b0};
    // Load-use: hold IF/ID, inject a bubble into EX.
    localparam ctrl_t CTRL_LD   = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b1,
                                    mem_wb_flush: 1'b0};
    // Memory wait: freeze everything up to MEM, bubble into WB.
    localparam ctrl_t CTRL_FRZ  = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                    ex_mem_en: 1'b0, mem_wb_en: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                    mem_wb_flush: 1'b1};

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: saturating event counter for pipeline statistics.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears to 0)
//   i_inc          : count one event this cycle
//   o_cnt          : current count, sticks at all-ones
module pipe_perf_cnt
    import pipe_pkg::*;
#(
    parameter int unsigned W = PERF_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_ld_use            : load-use hazard between EX and ID
//   i_br_taken          : branch in EX resolved taken
//   i_lsu_req/i_lsu_ack : MEM-stage memory access and its completion
//   o_pc_en, o_*_en     : PC and pipeline register enables
//   o_*_flush           : load NOP into IF/ID, ID/EX, MEM/WB
//   o_bus_err           : sticky, a memory wait hit MEM_TIMEOUT
// Optional (macro PIPE_CTRL_PERF_EN): o_stall_cycles, o_flush_cnt.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LD_BUBBLES  = 1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld_use,
    input  logic        i_br_taken,
    input  logic        i_lsu_req,
    input  logic        i_lsu_ack,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_mem_wb_flush,
    output logic        o_bus_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] o_stall_cycles,
    output logic [PERF_W-1:0] o_flush_cnt
`endif
);

    localparam logic [BUB_W-1:0]  BUB_LOAD = BUB_W'(LD_BUBBLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [BUB_W-1:0]  bub_q, bub_d, bub_dec;
    logic              bus_err_q, bus_err_d;
    logic              mem_wait, timeout;
    ctrl_t             run_ctrl, ctrl;

    always_comb begin
        mem_wait = i_lsu_req & ~i_lsu_ack;
        wait_inc = (wait_q == '1) ? wait_q : wait_q + 1'b1;
        timeout  = (wait_inc >= WAIT_MAX);
        bub_dec  = (bub_q == '0) ? '0 : bub_q - 1'b1;
        // RUN outputs with the memory condition ignored; also the release bundle.
        if (i_br_taken) begin
            run_ctrl = CTRL_BR;
        end else if (i_ld_use) begin
            run_ctrl = CTRL_LD;
        end else begin
            run_ctrl = CTRL_BASE;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bub_d     = bub_q;
        bus_err_d = bus_err_q;
        ctrl      = CTRL_BASE;
        case (state_q)
            ST_INIT: begin
                ctrl    = CTRL_INIT;
                state_d = ST_RUN;
                wait_d  = '0;
                bub_d   = '0;
            end
            ST_RUN: begin
                if (mem_wait) begin
                    ctrl    = CTRL_FRZ;
                    wait_d  = WAIT_W'(1);
                    state_d = ST_MEM_WAIT;
                end else begin
                    ctrl = run_ctrl;
                    if (!i_br_taken && i_ld_use && (LD_BUBBLES > 1)) begin
                        bub_d   = BUB_LOAD;
                        state_d = ST_LD_STALL;
                    end
                end
            end
            ST_LD_STALL: begin
                if (mem_wait) begin
                    ctrl    = CTRL_FRZ;
                    wait_d  = WAIT_W'(1);
                    bub_d   = '0;
                    state_d = ST_MEM_WAIT;
                end else begin
                    ctrl  = CTRL_LD;
                    bub_d = bub_dec;
                    if (bub_dec == '0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Ack wins over a coinciding timeout, so no error in that case.
                if (i_lsu_ack || timeout) begin
                    ctrl    = run_ctrl;
                    wait_d  = '0;
                    state_d = ST_RUN;
                    if (!i_lsu_ack) begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    ctrl   = CTRL_FRZ;
                    wait_d = wait_inc;
                end
            end
            default: begin
                ctrl    = CTRL_INIT;
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_INIT;
            wait_q    <= '0;
            bub_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bub_q     <= bub_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign o_pc_en        = ctrl.pc_en;
    assign o_if_id_en     = ctrl.if_id_en;
    assign o_id_ex_en     = ctrl.id_ex_en;
    assign o_ex_mem_en    = ctrl.ex_mem_en;
    assign o_mem_wb_en    = ctrl.mem_wb_en;
    assign o_if_id_flush  = ctrl.if_id_flush;
    assign o_id_ex_flush  = ctrl.id_ex_flush;
    assign o_mem_wb_flush = ctrl.mem_wb_flush;
    assign o_bus_err      = bus_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_evt, flush_evt;

    // Outside INIT, an IF/ID flush only ever comes from a taken branch.
    assign stall_evt = (state_q != ST_INIT) && !ctrl.pc_en;
    assign flush_evt = (state_q != ST_INIT) && ctrl.if_id_flush;

    pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (stall_evt),
        .o_cnt   (o_stall_cycles)
    );

    pipe_perf_cnt #(.W(PERF_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (flush_evt),
        .o_cnt   (o_flush_cnt)
    );
`endif

endmodule
